// File: rtl/ophd_trigger_regs.sv
// Interrupt trigger and interrupt-state registers ahead of the ophd decoder.
// Optional macro OPHD_NMI_FILTER_EN adds a 2-high/2-low qualifier on the NMI edge detector.
module ophd_trigger_regs #(
    parameter int SYNC_STAGES = 2,
    parameter int EI_DELAY    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       NMI_n,
    input  logic       INT_n,
    input  logic       BUSRQ_n,
    input  logic       P2_OpEnd,
    input  logic       P2_Set_IFF,
    input  logic       P2_Reset_IFF,
    input  logic       P2_Reset_IFF1,
    input  logic       P2_Reset_IFF2,
    input  logic       P2_EvacuateIFF,
    input  logic       P2_RestoreIFF,
    input  logic       P2_Set_IM,
    input  logic [1:0] IM_sel,
    input  logic       P2_Reset_TNMI,
    input  logic       P2_Reset_TINT,
    input  logic       P2_Set_LHALT,
    input  logic       P2_Reset_LHALT,
    output logic       TNMI,
    output logic       TINT,
    output logic       BUSRQ,
    output logic       notIFF1,
    output logic       IFF2,
    output logic       IMFa,
    output logic       IMFb,
    output logic       HALT_n
);

    localparam logic [1:0] EI_LOAD = 2'(EI_DELAY);

    logic [SYNC_STAGES-1:0] nmi_sync;
    logic [SYNC_STAGES-1:0] int_sync;
    logic [SYNC_STAGES-1:0] busrq_sync;
    logic                   nmi_s;
    logic                   int_s;
    logic                   busrq_s;
    logic                   nmi_fall;

    logic       iff1;
    logic       iff2_q;
    logic [1:0] ei_cnt;
    logic       lhalt;
    logic       iff1_nxt;
    logic       iff2_nxt;
    logic [1:0] ei_cnt_nxt;

    // Pin synchronisers: idle (deasserted) level is 1
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nmi_sync   <= '1;
            int_sync   <= '1;
            busrq_sync <= '1;
        end else begin
            nmi_sync[0]   <= NMI_n;
            int_sync[0]   <= INT_n;
            busrq_sync[0] <= BUSRQ_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                nmi_sync[i]   <= nmi_sync[i-1];
                int_sync[i]   <= int_sync[i-1];
                busrq_sync[i] <= busrq_sync[i-1];
            end
        end
    end

    assign nmi_s   = nmi_sync[SYNC_STAGES-1];
    assign int_s   = int_sync[SYNC_STAGES-1];
    assign busrq_s = busrq_sync[SYNC_STAGES-1];
    assign BUSRQ   = ~busrq_s;

`ifdef OPHD_NMI_FILTER_EN
    // hist[0] is the previous synchronised sample, hist[2] the oldest
    logic [2:0] nmi_hist;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) nmi_hist <= '1;
        else       nmi_hist <= {nmi_hist[1:0], nmi_s};
    end

    assign nmi_fall = nmi_hist[2] & nmi_hist[1] & ~nmi_hist[0] & ~nmi_s;
`else
    logic nmi_hist;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) nmi_hist <= 1'b1;
        else       nmi_hist <= nmi_s;
    end

    assign nmi_fall = nmi_hist & ~nmi_s;
`endif

    // A fresh edge beats a coincident clear so no NMI is dropped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            TNMI <= 1'b0;
            TINT <= 1'b0;
        end else begin
            TNMI <= nmi_fall | (TNMI & ~P2_Reset_TNMI);
            TINT <= ~int_s & ~P2_Reset_TINT;
        end
    end

    // IFF next state uses only pre-edge values, so evacuate+reset_iff1 swaps cleanly
    always_comb begin
        iff1_nxt   = iff1;
        iff2_nxt   = iff2_q;
        ei_cnt_nxt = ei_cnt;
        if (P2_Reset_IFF) begin
            iff1_nxt   = 1'b0;
            iff2_nxt   = 1'b0;
            ei_cnt_nxt = 2'd0;
        end else if (P2_Set_IFF) begin
            iff1_nxt   = 1'b1;
            iff2_nxt   = 1'b1;
            ei_cnt_nxt = EI_LOAD;
        end else begin
            if (P2_RestoreIFF)      iff1_nxt = iff2_q;
            else if (P2_Reset_IFF1) iff1_nxt = 1'b0;
            if (P2_EvacuateIFF)     iff2_nxt = iff1;
            else if (P2_Reset_IFF2) iff2_nxt = 1'b0;
            if (P2_OpEnd && ei_cnt != 2'd0) ei_cnt_nxt = ei_cnt - 2'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            iff1   <= 1'b0;
            iff2_q <= 1'b0;
            ei_cnt <= 2'd0;
        end else begin
            iff1   <= iff1_nxt;
            iff2_q <= iff2_nxt;
            ei_cnt <= ei_cnt_nxt;
        end
    end

    assign notIFF1 = ~iff1 | (ei_cnt != 2'd0);
    assign IFF2    = iff2_q;

    // IM_sel 3 is reserved and leaves the mode untouched
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            IMFa <= 1'b0;
            IMFb <= 1'b0;
        end else if (P2_Set_IM) begin
            case (IM_sel)
                2'd0: begin IMFa <= 1'b0; IMFb <= 1'b0; end
                2'd1: begin IMFa <= 1'b1; IMFb <= 1'b0; end
                2'd2: begin IMFa <= 1'b0; IMFb <= 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)               lhalt <= 1'b0;
        else if (P2_Reset_LHALT) lhalt <= 1'b0;
        else if (P2_Set_LHALT)   lhalt <= 1'b1;
    end

    assign HALT_n = ~lhalt;

endmodule

// File: tb/tb_ophd_trigger_regs.sv
// Directed bench for ophd_trigger_regs: strobe vector table plus pin-timing sequences.
module tb_ophd_trigger_regs;

    localparam int SYNC = 2;
`ifdef OPHD_NMI_FILTER_EN
    localparam int NMI_LAT = SYNC + 2;
    localparam logic GLITCH_SETS = 1'b0;
`else
    localparam int NMI_LAT = SYNC + 1;
    localparam logic GLITCH_SETS = 1'b1;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       NMI_n = 1'b1, INT_n = 1'b1, BUSRQ_n = 1'b1;
    logic       P2_OpEnd = 1'b0, P2_Set_IFF = 1'b0, P2_Reset_IFF = 1'b0;
    logic       P2_Reset_IFF1 = 1'b0, P2_Reset_IFF2 = 1'b0;
    logic       P2_EvacuateIFF = 1'b0, P2_RestoreIFF = 1'b0;
    logic       P2_Set_IM = 1'b0;
    logic [1:0] IM_sel = 2'd0;
    logic       P2_Reset_TNMI = 1'b0, P2_Reset_TINT = 1'b0;
    logic       P2_Set_LHALT = 1'b0, P2_Reset_LHALT = 1'b0;
    logic       TNMI, TINT, BUSRQ, notIFF1, IFF2, IMFa, IMFb, HALT_n;

    int errors = 0;
    int checks = 0;

    ophd_trigger_regs #(.SYNC_STAGES(SYNC), .EI_DELAY(2)) dut (
        .Clk(Clk), .Reset(Reset), .NMI_n(NMI_n), .INT_n(INT_n), .BUSRQ_n(BUSRQ_n),
        .P2_OpEnd(P2_OpEnd), .P2_Set_IFF(P2_Set_IFF), .P2_Reset_IFF(P2_Reset_IFF),
        .P2_Reset_IFF1(P2_Reset_IFF1), .P2_Reset_IFF2(P2_Reset_IFF2),
        .P2_EvacuateIFF(P2_EvacuateIFF), .P2_RestoreIFF(P2_RestoreIFF),
        .P2_Set_IM(P2_Set_IM), .IM_sel(IM_sel),
        .P2_Reset_TNMI(P2_Reset_TNMI), .P2_Reset_TINT(P2_Reset_TINT),
        .P2_Set_LHALT(P2_Set_LHALT), .P2_Reset_LHALT(P2_Reset_LHALT),
        .TNMI(TNMI), .TINT(TINT), .BUSRQ(BUSRQ), .notIFF1(notIFF1), .IFF2(IFF2),
        .IMFa(IMFa), .IMFb(IMFb), .HALT_n(HALT_n)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       im_set;
        logic [1:0] im_sel;
        logic       h_set, h_clr, di, ei, opend;
        logic       e_imfa, e_imfb, e_halt_n, e_notiff1, e_iff2;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " TNMI"}, TNMI, 1'b0);
        check({tag, " TINT"}, TINT, 1'b0);
        check({tag, " BUSRQ"}, BUSRQ, 1'b0);
        check({tag, " notIFF1"}, notIFF1, 1'b1);
        check({tag, " IFF2"}, IFF2, 1'b0);
        check({tag, " IMFa"}, IMFa, 1'b0);
        check({tag, " IMFb"}, IMFb, 1'b0);
        check({tag, " HALT_n"}, HALT_n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //           im  sel   hs    hc    di    ei    op  | imfa  imfb  haltn niff1 iff2
        vt[0]  = '{1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0};
        vt[1]  = '{1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
        vt[2]  = '{1'b1,2'd3,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
        vt[3]  = '{1'b1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
        vt[4]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
        vt[5]  = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
        vt[6]  = '{1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
        vt[7]  = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[8]  = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[9]  = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[10] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[11] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1};
        vt[12] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1};
        vt[13] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[14] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
        vt[15] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1};
        vt[16] = '{1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
        vt[17] = '{1'b1,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0};
        vt[18] = '{1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
        vt[19] = '{1'b0,2'd0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
        vt[20] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b0};

        step();
        step();
        Reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < NV; i++) begin
            P2_Set_IM = vt[i].im_set;   IM_sel = vt[i].im_sel;
            P2_Set_LHALT = vt[i].h_set; P2_Reset_LHALT = vt[i].h_clr;
            P2_Reset_IFF = vt[i].di;    P2_Set_IFF = vt[i].ei;
            P2_OpEnd = vt[i].opend;
            step();
            check($sformatf("vec%0d IMFa", i), IMFa, vt[i].e_imfa);
            check($sformatf("vec%0d IMFb", i), IMFb, vt[i].e_imfb);
            check($sformatf("vec%0d HALT_n", i), HALT_n, vt[i].e_halt_n);
            check($sformatf("vec%0d notIFF1", i), notIFF1, vt[i].e_notiff1);
            check($sformatf("vec%0d IFF2", i), IFF2, vt[i].e_iff2);
        end
        P2_Set_IM = 1'b0; P2_Set_LHALT = 1'b0; P2_Reset_LHALT = 1'b0;
        P2_Reset_IFF = 1'b0; P2_Set_IFF = 1'b0; P2_OpEnd = 1'b0;

        // BUSRQ latency
        BUSRQ_n = 1'b0;
        for (int k = 1; k < SYNC; k++) begin
            step();
            check($sformatf("busrq edge%0d", k), BUSRQ, 1'b0);
        end
        step();
        check("busrq asserted", BUSRQ, 1'b1);
        BUSRQ_n = 1'b1;
        repeat (SYNC) step();
        check("busrq released", BUSRQ, 1'b0);

        // NMI edge: latency, clear while held low, no re-trigger
        NMI_n = 1'b0;
        for (int k = 1; k < NMI_LAT; k++) begin
            step();
            check($sformatf("nmi edge%0d", k), TNMI, 1'b0);
        end
        step();
        check("nmi set", TNMI, 1'b1);
        P2_Reset_TNMI = 1'b1;
        step();
        P2_Reset_TNMI = 1'b0;
        check("nmi cleared", TNMI, 1'b0);
        repeat (3) step();
        check("nmi held low no retrigger", TNMI, 1'b0);
        NMI_n = 1'b1;
        repeat (SYNC + 3) step();
        check("nmi idle", TNMI, 1'b0);

        // 5-cycle pulse: trigger survives the pin returning high
        NMI_n = 1'b0;
        repeat (5) step();
        NMI_n = 1'b1;
        repeat (SYNC + 3) step();
        check("nmi sticky after release", TNMI, 1'b1);

        // New edge coincident with the clear strobe
        NMI_n = 1'b0;
        repeat (NMI_LAT - 1) step();
        P2_Reset_TNMI = 1'b1;
        step();
        P2_Reset_TNMI = 1'b0;
        check("nmi set beats clear", TNMI, 1'b1);
        P2_Reset_TNMI = 1'b1;
        step();
        P2_Reset_TNMI = 1'b0;
        check("nmi clear alone", TNMI, 1'b0);
        NMI_n = 1'b1;
        repeat (SYNC + 3) step();

        // One-cycle low glitch
        NMI_n = 1'b0;
        step();
        NMI_n = 1'b1;
        repeat (SYNC + 4) step();
        check("nmi glitch", TNMI, GLITCH_SETS);
        P2_Reset_TNMI = 1'b1;
        step();
        P2_Reset_TNMI = 1'b0;

        // INT level with reset strobe
        INT_n = 1'b0;
        repeat (SYNC) step();
        check("int before latency", TINT, 1'b0);
        step();
        check("int set", TINT, 1'b1);
        P2_Reset_TINT = 1'b1;
        step();
        P2_Reset_TINT = 1'b0;
        check("int cleared by strobe", TINT, 1'b0);
        step();
        check("int reasserts", TINT, 1'b1);
        INT_n = 1'b1;
        repeat (SYNC + 1) step();
        check("int released", TINT, 1'b0);

        // NMI acceptance: evacuate IFF1 into IFF2 while clearing IFF1, then RETN
        P2_Set_IFF = 1'b1; step(); P2_Set_IFF = 1'b0;
        P2_OpEnd = 1'b1; step(); step(); P2_OpEnd = 1'b0;
        check("iff enabled", notIFF1, 1'b0);
        P2_Reset_IFF2 = 1'b1; step(); P2_Reset_IFF2 = 1'b0;
        check("iff2 cleared", IFF2, 1'b0);
        check("iff1 kept", notIFF1, 1'b0);
        P2_EvacuateIFF = 1'b1; P2_Reset_IFF1 = 1'b1;
        step();
        P2_EvacuateIFF = 1'b0; P2_Reset_IFF1 = 1'b0;
        check("evac IFF2", IFF2, 1'b1);
        check("evac notIFF1", notIFF1, 1'b1);
        P2_RestoreIFF = 1'b1; step(); P2_RestoreIFF = 1'b0;
        check("restore notIFF1", notIFF1, 1'b0);
        check("restore IFF2", IFF2, 1'b1);

        // Asynchronous reset in the middle of activity
        INT_n = 1'b0; NMI_n = 1'b0; BUSRQ_n = 1'b0;
        P2_Set_LHALT = 1'b1; P2_Set_IM = 1'b1; IM_sel = 2'd2;
        step();
        P2_Set_LHALT = 1'b0; P2_Set_IM = 1'b0;
        repeat (NMI_LAT) step();
        check("pre-reset TNMI", TNMI, 1'b1);
        check("pre-reset TINT", TINT, 1'b1);
        check("pre-reset BUSRQ", BUSRQ, 1'b1);
        check("pre-reset HALT_n", HALT_n, 1'b0);
        check("pre-reset IMFb", IMFb, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check_reset_values("async reset");
        step();
        check_reset_values("reset held");
        Reset = 1'b0;
        INT_n = 1'b1; NMI_n = 1'b1; BUSRQ_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ophd_trigger_regs.md
Name: ophd_trigger_regs

Overview:
- Upstream neighbour of the opcode-head (ophd) decoder.
- Synchronises the external NMI, INT and BUSRQ pins and latches the NMI edge trigger (TNMI) and INT level trigger (TINT).
- Holds the interrupt flip-flops IFF1/IFF2, the interrupt-mode flags IMFa/IMFb and the HALT latch.
- Supplies TNMI, TINT, BUSRQ, notIFF1, IMFa and IMFb to the ophd decoder, and consumes that decoder's P2_* reset and evacuate strobes plus strobes from the instruction decoders.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for the pin inputs; minimum 1.
- EI_DELAY, 2: number of P2_OpEnd strobes after EI during which interrupts stay masked; range 1-3.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- NMI_n  in  1  NMI pin, active low, asynchronous.
- INT_n  in  1  INT pin, active low, asynchronous.
- BUSRQ_n  in  1  bus request pin, active low, asynchronous.
- P2_OpEnd  in  1  one-cycle strobe marking the end of each instruction.
- P2_Set_IFF  in  1  EI strobe.
- P2_Reset_IFF  in  1  DI strobe.
- P2_Reset_IFF1  in  1  from the ophd decoder.
- P2_Reset_IFF2  in  1  from the ophd decoder.
- P2_EvacuateIFF  in  1  from the ophd decoder: IFF2 <= IFF1.
- P2_RestoreIFF  in  1  RETN strobe: IFF1 <= IFF2.
- P2_Set_IM  in  1  IM n strobe.
- IM_sel  in  2  mode operand for P2_Set_IM: 0, 1 or 2.
- P2_Reset_TNMI  in  1  from the ophd decoder.
- P2_Reset_TINT  in  1  from the ophd decoder.
- P2_Set_LHALT  in  1  HALT instruction strobe.
- P2_Reset_LHALT  in  1  from the ophd decoder.
- TNMI  out  1  pending-NMI trigger.
- TINT  out  1  pending-INT trigger.
- BUSRQ  out  1  synchronised bus request, active high.
- notIFF1  out  1  interrupt mask seen by the ophd decoder.
- IFF2  out  1  for LD A,I / LD A,R flag logic.
- IMFa  out  1  interrupt-mode flag a.
- IMFb  out  1  interrupt-mode flag b.
- HALT_n  out  1  HALT pin, active low.

Behaviour:
- Reset (asynchronous, any time including mid-instruction):
  - Synchroniser flops go to 1 (pins deasserted).
  - TNMI=0, TINT=0, BUSRQ=0.
  - IFF1=IFF2=0, so notIFF1=1.
  - EI counter=0; IMFa=IMFb=0; LHALT=0, so HALT_n=1.
- Synchronisers: each pin passes through SYNC_STAGES flops. The BUSRQ output equals the inverted synchronised BUSRQ_n, giving SYNC_STAGES cycles of pin-to-output latency.
- NMI edge detect:
  - A registered copy of the synchronised NMI_n is kept. A 1->0 transition sets TNMI on the next edge.
  - TNMI holds until P2_Reset_TNMI.
  - If a new edge and P2_Reset_TNMI occur in the same cycle, the set wins, so the NMI is not lost.
  - NMI_n held low does not re-trigger.
- INT (level): TINT <= synchronised INT active AND NOT P2_Reset_TINT. If the pin is still low after a reset strobe, TINT reasserts on the following cycle.
- IFF next-state, with priorities from highest to lowest:
  1. P2_Reset_IFF (DI): IFF1=IFF2=0 and EI counter cleared.
  2. P2_Set_IFF (EI): IFF1=IFF2=1 and EI counter loaded with EI_DELAY.
  3. P2_RestoreIFF: IFF1 <= IFF2.
  4. P2_Reset_IFF1 / P2_Reset_IFF2: clear the respective flop.
- P2_EvacuateIFF: IFF2 <= old IFF1. It is evaluated from pre-edge values, so combining it with P2_Reset_IFF1 (the NMI acceptance case) gives IFF2=old IFF1 and IFF1=0.
- EI counter:
  - Decrements on each P2_OpEnd while non-zero; saturates at 0.
  - An EI and an OpEnd in the same cycle reload the counter (no decrement).
  - Consecutive EIs keep reloading, so the mask is held.
- notIFF1 = NOT IFF1 OR (EI counter != 0). It is registered-path only; there is no combinational path from any strobe input.
- IM flags, updated on P2_Set_IM:
  - IM_sel 0 -> IMFa=0, IMFb=0.
  - IM_sel 1 -> IMFa=1, IMFb=0.
  - IM_sel 2 -> IMFa=0, IMFb=1.
  - IM_sel 3 -> no change.
- HALT latch:
  - LHALT set by P2_Set_LHALT and cleared by P2_Reset_LHALT; reset wins if both occur in one cycle.
  - HALT_n = NOT LHALT, registered.

Optional Feature:
- Macro OPHD_NMI_FILTER_EN.
- Defined: an NMI edge is accepted only when the synchronised NMI_n has been 1 for at least 2 consecutive cycles and then 0 for 2 consecutive cycles. TNMI therefore sets one cycle later than without the filter. A 1-cycle low glitch is ignored.
- Undefined: any single 1->0 transition of the synchronised signal sets TNMI.

Test Plan:
- Release Reset, then pulse NMI_n low for 5 cycles -> TNMI=1 exactly SYNC_STAGES+1 edges after the fall; stays 1 after NMI_n returns high; cleared by P2_Reset_TNMI; no re-set while NMI_n is held low.
- New NMI edge coincident with P2_Reset_TNMI -> TNMI remains 1.
- IFF1=1, assert P2_EvacuateIFF and P2_Reset_IFF1 together -> IFF2=1, IFF1=0, notIFF1=1; then P2_RestoreIFF -> IFF1=1.
- EI strobe with EI_DELAY=2 -> notIFF1=1 after the first P2_OpEnd, 0 after the second; EI repeated before the second OpEnd -> still 1 after it.
- P2_Set_IM with IM_sel 2, 1, 3, 0 -> (IMFa,IMFb) = (0,1), (1,0), (1,0), (0,0).
- INT_n held low with P2_Reset_TINT pulsed -> TINT 0 for one cycle, then 1; with P2_Set_LHALT followed by P2_Reset_LHALT -> HALT_n 0 then 1; Reset asserted mid-sequence -> all outputs return to reset values asynchronously.
